// File: rtl/keypad_entry_scanner.sv
// keypad_entry_scanner: scans a 4x4 active-low keypad, debounces whole-scan
// snapshots and accumulates decimal digit presses into a 13-bit number.
module keypad_entry_scanner #(
  parameter int unsigned CLKS_PER_COL   = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned MAX_VALUE      = 8191
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [12:0] entry,
  output logic [2:0]  digits,
  output logic [12:0] value,
  output logic        value_valid,
  output logic        key_strobe,
  output logic [3:0]  key_code,
  output logic        reject
);

  localparam int unsigned DIV_W   = (CLKS_PER_COL > 1) ? $clog2(CLKS_PER_COL) : 1;
  localparam int unsigned STB_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam int unsigned VAL_W   = 13;
  localparam int unsigned ARITH_W = 17;
  localparam int unsigned KEYS    = 16;

  logic [3:0]         row_s1, row_s2;
  logic [DIV_W-1:0]   div_cnt;
  logic [1:0]         col_idx;
  logic [KEYS-1:0]    snap, prev_snap, deb, deb_q;
  logic [STB_W-1:0]   stable_cnt;

  logic               col_tick_c;
  logic               scan_done_c;
  logic [KEYS-1:0]    snap_next_c;
  logic [STB_W-1:0]   stable_next_c;
  logic               press_c;
  logic [3:0]         press_idx_c;
  logic [3:0]         press_code_c;
  logic [ARITH_W-1:0] prod_c;
  logic               digit_ok_c;

  // Matrix position (4*row + col) to key code.
  function automatic logic [3:0] code_of(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'd10;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = 4'd11;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = 4'd12;
      4'd12:   code = 4'd14;
      4'd13:   code = 4'd0;
      4'd14:   code = 4'd15;
      default: code = 4'd13;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= '0;
      row_s2 <= '0;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  assign col_tick_c  = (div_cnt == DIV_W'(CLKS_PER_COL - 1));
  assign scan_done_c = col_tick_c && (col_idx == 2'd3);

  // Column divider and registered column drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      col_idx <= '0;
      col     <= 4'b1110;
    end else if (col_tick_c) begin
      div_cnt <= '0;
      col_idx <= col_idx + 2'd1;
      col     <= ~(4'b0001 << (col_idx + 2'd1));
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Snapshot with the current column's pressed rows merged in.
  always_comb begin
    snap_next_c = snap;
    for (int r = 0; r < 4; r++) begin
      snap_next_c[{2'(r), col_idx}] = ~row_s2[2'(r)];
    end
  end

  // Consecutive-identical-scan counter, saturating at the debounce depth.
  always_comb begin
    stable_next_c = stable_cnt;
    if (snap_next_c != prev_snap) begin
      stable_next_c = '0;
    end else if (stable_cnt != STB_W'(DEBOUNCE_SCANS)) begin
      stable_next_c = stable_cnt + STB_W'(1);
    end
  end

  // Snapshot capture and debounced key state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap       <= '0;
      prev_snap  <= '0;
      stable_cnt <= '0;
      deb        <= '0;
    end else if (col_tick_c) begin
      snap <= snap_next_c;
      if (scan_done_c) begin
        prev_snap  <= snap_next_c;
        stable_cnt <= stable_next_c;
        if ((stable_next_c == STB_W'(DEBOUNCE_SCANS)) &&
            (stable_cnt != STB_W'(DEBOUNCE_SCANS))) begin
          deb <= snap_next_c;
        end
      end
    end
  end

  // Delayed debounced state for idle-to-single-key edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= '0;
    end else begin
      deb_q <= deb;
    end
  end

  assign press_c = (deb_q == '0) && $onehot(deb);

  // Position of the single pressed key.
  always_comb begin
    press_idx_c = '0;
    for (int i = 0; i < KEYS; i++) begin
      if (deb[4'(i)]) begin
        press_idx_c = 4'(i);
      end
    end
  end

  assign press_code_c = code_of(press_idx_c);
  assign prod_c       = ARITH_W'(entry) * ARITH_W'(10) + ARITH_W'(press_code_c);
  assign digit_ok_c   = (digits < 3'd4) && (prod_c <= ARITH_W'(MAX_VALUE));

  // Entry accumulator, commit and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry       <= '0;
      digits      <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      key_strobe  <= 1'b0;
      key_code    <= '0;
      reject      <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      key_strobe  <= 1'b0;
      reject      <= 1'b0;
      if (press_c) begin
        key_strobe <= 1'b1;
        key_code   <= press_code_c;
        if (press_code_c <= 4'd9) begin
          if (digit_ok_c) begin
            entry  <= VAL_W'(prod_c);
            digits <= digits + 3'd1;
          end else begin
            reject <= 1'b1;
          end
        end else begin
          case (press_code_c)
            4'd13: begin
              if (digits != 3'd0) begin
                entry  <= entry / VAL_W'(10);
                digits <= digits - 3'd1;
              end
            end
            4'd14: begin
              entry  <= '0;
              digits <= '0;
            end
            4'd15: begin
              if (digits != 3'd0) begin
                value       <= entry;
                value_valid <= 1'b1;
                entry       <= '0;
                digits      <= '0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/keypad_entry_scanner.md
# keypad_entry_scanner

Scans a 4x4 matrix keypad, debounces it, and turns key presses into a decimal number of up to four digits, 0..8191. It is the input half of the board's numeric user interface. Its live `entry` output feeds the 13-bit number input of the four-digit seven-segment driver, so digits appear on the display as they are typed. A committed `value` with a one-cycle `value_valid` pulse goes to the processor I/O logic.

## Interface
- `CLKS_PER_COL`, default 50000: clock cycles each column stays driven.
- `DEBOUNCE_SCANS`, default 4: number of consecutive identical full scans needed before a new key state is accepted.
- `MAX_VALUE`, default 8191: largest value that can be entered; must fit in 13 bits.
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `row` in 4: keypad row lines, active-low (pulled up); asynchronous to `clk`.
- `col` out 4: keypad column drive, active-low, exactly one bit low at a time.
- `entry` out 13: accumulator value being typed.
- `digits` out 3: number of digits in `entry`, 0..4.
- `value` out 13: last committed number.
- `value_valid` out 1: one-cycle pulse when `value` is updated.
- `key_strobe` out 1: one-cycle pulse for each accepted key press.
- `key_code` out 4: code of the last accepted key; held between strobes.
- `reject` out 1: one-cycle pulse when a digit key is refused.

## Operation
- Key map by row r (0 = top) and column c (0 = left):
  - Row 0: `1 2 3 A`
  - Row 1: `4 5 6 B`
  - Row 2: `7 8 9 C`
  - Row 3: `* 0 #  D`
- `key_code` encoding:
  - Digits 0..9 map to codes 0..9.
  - A = 10, B = 11, C = 12, `*` = 14, `#` = 15, D = 13.
- Row synchronizer: `row` passes through a 2-flop synchronizer before any use.
- Scan counter:
  - `col_idx` (0..3) and `div_cnt` (0..CLKS_PER_COL-1) drive `col = ~(1 << col_idx)`.
  - When `div_cnt` = CLKS_PER_COL-1, the inverted synchronized row is stored into snapshot bits [4*r + c], `div_cnt` returns to 0 and `col_idx` increments, wrapping 3 -> 0.
- Scan completion occurs when the column-3 sample is taken:
  - Snapshot equals the previous snapshot: `stable_cnt` increments, saturating at DEBOUNCE_SCANS.
  - Snapshot differs: `stable_cnt` is cleared to 0.
  - The debounced state takes the snapshot value on the scan that brings `stable_cnt` to DEBOUNCE_SCANS.
- Press event: the debounced state changes from all-zero to exactly one bit set.
  - Two or more keys pressed together: no event. A new event requires the state to return to all-zero first.
  - A held key produces no auto-repeat.
- Entry actions, taken on each press event:
  - Digit d:
    - Accepted when `digits` < 4 and `entry*10 + d` ≤ MAX_VALUE. `entry` becomes `entry*10 + d` and `digits` increments.
    - Otherwise `entry` and `digits` are unchanged and `reject` pulses.
  - `D` (backspace): when `digits` > 0, `entry` becomes `entry/10` and `digits` decrements; when `digits` = 0, nothing changes.
  - `*` (clear): `entry` = 0, `digits` = 0.
  - `#` (enter):
    - When `digits` > 0: `value` takes `entry`, `value_valid` pulses, then `entry` = 0 and `digits` = 0.
    - When `digits` = 0: ignored, no pulse.
  - A, B, C: `key_strobe` pulses and `key_code` updates; `entry` and `value` are unchanged.
- Arithmetic width: `entry*10 + d` is evaluated at 17 bits so the MAX_VALUE comparison cannot wrap.

## Timing
- Reset values (asynchronous, on `rst_n` = 0):
  - `col` = 4'b1110; `col_idx`, `div_cnt` = 0.
  - Synchronizer, snapshots, `stable_cnt`, debounced state = 0.
  - `entry`, `digits`, `value`, `key_code` = 0.
  - `value_valid`, `key_strobe`, `reject` = 0.
- Reset mid-operation: a partial entry is discarded. Scanning restarts at column 0 on the first rising edge after `rst_n` deasserts.
- Full scan period = 4·CLKS_PER_COL cycles.
- Minimum press-to-accept delay = DEBOUNCE_SCANS scans after the first scan that sees the key, plus 2 synchronizer cycles.
- Cycle N: debounced state updates.
  - Cycle N+1: `key_strobe`, `reject` and `value_valid` are high, `key_code` is valid, and `entry`/`digits` are updated.
  - `value` and `value_valid` change in the same cycle.
- All pulses last exactly one cycle; at most one press event occurs per scan.

## Test plan
Bench parameters: CLKS_PER_COL = 4, DEBOUNCE_SCANS = 2; one scan = 16 cycles. Each key is held 4 scans, then released 4 scans.
- Reset: hold `rst_n` low, then release -> `col` = 1110, walking 1101, 1011, 0111 every 4 cycles; all outputs 0.
- Keys 1, 2, 3, 4 -> `entry` = 1, 12, 123, 1234; `digits` reaches 4; four `key_strobe` pulses with `key_code` 1, 2, 3, 4. Then `#` -> `value` = 1234, one `value_valid` pulse, `entry` = 0.
- Keys 9, 9, 9, 9 -> `entry` = 999 with a `reject` pulse on the fourth 9. Then `*`, then 8, 1, 9, 1 -> `entry` = 8191; a further 5 -> `reject`, `entry` stays 8191.
- Keys 1, 2, 3, D -> `entry` = 12, `digits` = 2. Then D, D, D -> `entry` 1, 0, 0 with `digits` 1, 0, 0. Then `#` -> no `value_valid`.
- Bounce and multi-key:
  - Key 5 toggled every scan for 6 scans -> no `key_strobe`.
  - Keys 5 and 6 held together -> no `key_strobe`; releasing 6 while 5 stays held -> no `key_strobe`.
- Reset mid-entry: `entry` = 12 when `rst_n` is pulsed low -> `entry` = 0 and `digits` = 0 immediately; `value` = 0.
